// File: rtl/fetch_queue_unit.sv
// Instruction fetcher with one outstanding ICache request and a 2^FQ_WIDTH-entry fetch queue.
// Optional return-address stack is built only when IF_RAS_EN is defined.
module fetch_queue_unit #(
  parameter int          FQ_WIDTH  = 3,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          RAS_WIDTH = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  output logic                icache_query_en,
  output logic [31:0]         icache_query_pc,
  input  logic                icache_data_en,
  input  logic [31:0]         icache_addr_comfirm,
  input  logic [31:0]         icache_data,
  output logic [31:0]         predict_query_pc,
  input  logic                predict_result,
  input  logic                flush_en,
  input  logic [31:0]         flush_pc,
  input  logic                jalr_result_en,
  input  logic [31:0]         jalr_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_pc,
  output logic [31:0]         out_inst,
  output logic                out_predict,
  output logic [FQ_WIDTH:0]   fq_count
);

  localparam int FQ_SIZE = 1 << FQ_WIDTH;
  localparam logic [FQ_WIDTH:0]   FQ_FULL  = {1'b1, {FQ_WIDTH{1'b0}}};
  localparam logic [FQ_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [FQ_WIDTH-1:0] PTR_ONE  = 1;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {S_FETCH, S_WAIT_IC, S_WAIT_JALR} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } fq_entry_t;

  state_t              state;
  logic [31:0]         pc;
  fq_entry_t           fq_mem [FQ_SIZE];
  logic [FQ_WIDTH-1:0] wr_ptr;
  logic [FQ_WIDTH-1:0] rd_ptr;
  logic [FQ_WIDTH:0]   count;

  logic        accept;
  logic        fq_push;
  logic        fq_pop;
  logic [6:0]  opcode;
  logic [31:0] imm_j;
  logic [31:0] imm_b;
  logic [31:0] pc_plus4;
  logic [31:0] dec_next_pc;
  logic        dec_pred;
  logic        dec_wait_jalr;

`ifdef IF_RAS_EN
  localparam int RAS_SIZE = 1 << RAS_WIDTH;
  localparam logic [RAS_WIDTH:0]   RAS_FULL    = {1'b1, {RAS_WIDTH{1'b0}}};
  localparam logic [RAS_WIDTH:0]   RAS_CNT_ONE = 1;
  localparam logic [RAS_WIDTH-1:0] RAS_PTR_ONE = 1;

  logic [31:0]          ras_mem [RAS_SIZE];
  logic [RAS_WIDTH-1:0] ras_top;
  logic [RAS_WIDTH:0]   ras_cnt;
  logic [RAS_WIDTH-1:0] ras_top_m1;
  logic                 link_rd;
  logic                 link_rs1;
  logic                 ras_push;
  logic                 ras_pop;
`endif

  assign predict_query_pc = icache_query_pc;
  assign out_valid        = (count != '0);
  assign fq_count         = count;
  assign out_pc           = fq_mem[rd_ptr].pc;
  assign out_inst         = fq_mem[rd_ptr].inst;
  assign out_predict      = fq_mem[rd_ptr].pred;

  // Decode of the word currently on the ICache response bus.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    accept        = (state == S_WAIT_IC) && icache_data_en &&
                    (icache_addr_comfirm == icache_query_pc);
    fq_push       = rst_in && rdy_in && !flush_en && accept;
    fq_pop        = out_valid && out_ready;
    opcode        = icache_data[6:0];
    imm_j         = {{12{icache_data[31]}}, icache_data[19:12], icache_data[20],
                     icache_data[30:21], 1'b0};
    imm_b         = {{20{icache_data[31]}}, icache_data[7], icache_data[30:25],
                     icache_data[11:8], 1'b0};
    pc_plus4      = pc + 32'd4;
    dec_next_pc   = pc_plus4;
    dec_pred      = 1'b0;
    dec_wait_jalr = 1'b0;
    case (opcode)
      OP_JAL: begin
        dec_next_pc = pc + imm_j;
        dec_pred    = 1'b1;
      end
      OP_BRANCH: begin
        dec_pred = predict_result;
        if (predict_result) dec_next_pc = pc + imm_b;
      end
      OP_JALR: begin
        dec_next_pc   = pc;
        dec_wait_jalr = 1'b1;
      end
      default: ;
    endcase
`ifdef IF_RAS_EN
    ras_top_m1 = ras_top - RAS_PTR_ONE;
    link_rd    = (icache_data[11:7] == 5'd1) || (icache_data[11:7] == 5'd5);
    link_rs1   = (icache_data[19:15] == 5'd1) || (icache_data[19:15] == 5'd5);
    ras_push   = ((opcode == OP_JAL) || (opcode == OP_JALR)) && link_rd;
    ras_pop    = (opcode == OP_JALR) && (icache_data[11:7] == 5'd0) && link_rs1 &&
                 (ras_cnt != '0);
    if (ras_pop) begin
      dec_next_pc   = ras_mem[ras_top_m1];
      dec_pred      = 1'b1;
      dec_wait_jalr = 1'b0;
    end
`endif
  end

  // Storage arrays: written only on a committed push.
  always_ff @(posedge clk_in) begin
    // NOTE: the arrays have no reset; count and pointers alone say which entries are live.
    if (fq_push) fq_mem[wr_ptr] <= fq_entry_t'{pc: pc, inst: icache_data, pred: dec_pred};
`ifdef IF_RAS_EN
    if (fq_push && ras_push) ras_mem[ras_top] <= pc_plus4;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state           <= S_FETCH;
      pc              <= RESET_PC;
      icache_query_en <= 1'b0;
      icache_query_pc <= 32'h0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
`ifdef IF_RAS_EN
      ras_top         <= '0;
      ras_cnt         <= '0;
`endif
    end else if (rdy_in) begin
      if (flush_en) begin
        state           <= S_FETCH;
        pc              <= flush_pc;
        icache_query_en <= 1'b0;
        wr_ptr          <= rd_ptr;
        count           <= '0;
      end else begin
        case (state)
          S_FETCH: begin
            if (count < FQ_FULL) begin
              icache_query_en <= 1'b1;
              icache_query_pc <= pc;
              state           <= S_WAIT_IC;
            end
          end
          S_WAIT_IC: begin
            if (accept) begin
              icache_query_en <= 1'b0;
              pc              <= dec_next_pc;
              state           <= dec_wait_jalr ? S_WAIT_JALR : S_FETCH;
`ifdef IF_RAS_EN
              if (ras_pop) begin
                ras_top <= ras_top_m1;
                ras_cnt <= ras_cnt - RAS_CNT_ONE;
              end else if (ras_push) begin
                ras_top <= ras_top + RAS_PTR_ONE;
                if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + RAS_CNT_ONE;
              end
`endif
            end
          end
          S_WAIT_JALR: begin
            if (jalr_result_en) begin
              pc    <= jalr_result & 32'hFFFF_FFFE;
              state <= S_FETCH;
            end
          end
          default: state <= S_FETCH;
        endcase
        if (fq_push) wr_ptr <= wr_ptr + PTR_ONE;
        if (fq_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        case ({fq_push, fq_pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised successor to the single-entry instruction fetcher. Keeps one ICache request outstanding and buffers fetched instructions in a FIFO of 2^FQ_WIDTH entries. Decodes control flow from raw opcode bits, with static or predictor-driven redirects. Sits between ICache/Branch_Predictor and the Dispatcher and supports a one-cycle flush on misprediction.

Parameters:
FQ_WIDTH, 3, log2 of fetch-queue depth (FQ_SIZE = 1 << FQ_WIDTH)
RESET_PC, 32'h0, PC loaded at reset
RAS_WIDTH, 2, log2 of return-address-stack depth (used only with IF_RAS_EN)

Ports:
clk_in  in  1  clock, all logic on posedge
rst_in  in  1  synchronous reset, active-low (0 = reset)
rdy_in  in  1  global enable; 0 freezes all state
icache_query_en  out  1  fetch request valid, held until accepted response
icache_query_pc  out  32  fetch address
icache_data_en  in  1  response valid
icache_addr_comfirm  in  32  address of returned word
icache_data  in  32  instruction word
predict_query_pc  out  32  equals icache_query_pc (combinational)
predict_result  in  1  1 = predict taken
flush_en  in  1  misprediction redirect from RoB
flush_pc  in  32  correct next PC
jalr_result_en  in  1  resolved jalr target valid
jalr_result  in  32  jalr target
out_valid  out  1  FIFO non-empty
out_ready  in  1  Dispatcher accepts head
out_pc  out  32  head PC
out_inst  out  32  head raw instruction
out_predict  out  1  head prediction (taken/not-taken; 1 for jal)
fq_count  out  FQ_WIDTH+1  occupancy

Behaviour:
- Reset (rst_in=0 on clock edge): pc=RESET_PC, state=FETCH, FIFO empty, icache_query_en=0, icache_query_pc=0, RAS empty. Outputs: out_valid=0, fq_count=0.
- rdy_in=0: no state changes; a flush is ignored.
- Priority: reset > flush > normal operation.
- FETCH: if fq_count < FQ_SIZE, set icache_query_en=1, icache_query_pc=pc, go to WAIT_IC. Otherwise stay in FETCH.
- WAIT_IC: accept a response only when icache_data_en=1 and icache_addr_comfirm==icache_query_pc; otherwise ignore. On accept:
  - icache_query_en=0.
  - Push {pc, word, pred} to the FIFO.
  - Next pc, using opcode = word[6:0]:
    - 1101111 (jal): pc+J-imm, pred=1.
    - 1100011 (branch): predict_result ? pc+B-imm : pc+4; pred=predict_result.
    - 1100111 (jalr): go to WAIT_JALR, pc unchanged.
    - Otherwise: pc+4.
  - All other accepted cases return to FETCH.
- Immediates are sign-extended to 32 bits. Adds wrap mod 2^32.
- WAIT_JALR: on jalr_result_en, pc = jalr_result & ~1, go to FETCH.
- Fetch-to-push latency is ICache latency + 1. At most one request is outstanding. A request issues only with a guaranteed free slot, so a push never finds the FIFO full.
- Pop: when out_valid && out_ready the head advances. Simultaneous push and pop leaves fq_count unchanged. Pointers wrap mod FQ_SIZE.
- out_* are read combinationally from the head entry. When empty, out_* hold their last values and are don't-care.
- Flush: pc=flush_pc, FIFO cleared (fq_count=0), icache_query_en=0, state=FETCH.
  - A response or pop in the same cycle is discarded.
  - A late stale response is rejected by the address compare. Equal-address data is valid and is accepted.
  - The RAS is not restored.
- out_valid never rises in the flush cycle.

Optional Feature:
IF_RAS_EN:
- Defined: adds a return-address stack of 2^RAS_WIDTH entries.
  - jal/jalr with rd in {x1,x5}: push pc+4. On overflow, overwrite the oldest entry (circular).
  - jalr with rd=x0, rs1 in {x1,x5}, RAS non-empty: pop, next pc = popped value, pred=1, no WAIT_JALR. The RoB checks this via flush.
  - Other jalr, or RAS empty: WAIT_JALR as without the feature.
- Undefined: every jalr enters WAIT_JALR. No RAS logic is generated.

Test Plan:
1. Reset, then words 0x00000013 (addi) at 0/4/8, out_ready=1 -> queries 0,4,8 in order; out_pc 0,4,8; fq_count ≤1.
2. out_ready=0, FQ_WIDTH=3, straight-line code -> fetching stops at fq_count=8 with icache_query_en=0. Raise out_ready -> fetching resumes, FIFO order preserved.
3. Branch 0xFE000EE3 (beq x0,x0,-4) at 0x10 with predict_result=1 -> next query 0x0C, out_predict=1. With predict_result=0 -> next query 0x14, out_predict=0.
4. jalr at 0x20 (no RAS) -> state waits, no queries. jalr_result_en with 0x101 -> next query 0x100.
5. fq_count=5 with a query outstanding, flush_en with flush_pc=0x200 -> next cycle fq_count=0, out_valid=0. A stale response for the old addr is dropped; next query is 0x200.
6. IF_RAS_EN: jal ra at 0x40, callee ret (0x00008067) -> next fetch after ret is 0x44 with no WAIT_JALR stall.
